// File: rtl/act_row_writer.sv
// Realigns skewed activation lanes from the systolic array and writes each row as one word to the unified buffer.
// Optional macro ACT_ROW_WRITER_RELU_EN applies ReLU to every aligned lane before the output register.
module act_row_writer #(
   parameter int DATA_WIDTH = 8,
   parameter int ARR_INPUTS = 4,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [ADDR_WIDTH-1:0]              base_addr,
   input  logic [ADDR_WIDTH-1:0]              num_rows,
   input  logic                               in_valid,
   input  logic [DATA_WIDTH*ARR_INPUTS-1:0]   in_data,
   output logic                               mem_wr_en,
   output logic [ADDR_WIDTH-1:0]              mem_wr_addr,
   output logic [DATA_WIDTH*ARR_INPUTS-1:0]   mem_wr_data,
   output logic                               busy,
   output logic                               done
);

   localparam int ROW_W = DATA_WIDTH*ARR_INPUTS;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_cnt;
   logic [ADDR_WIDTH-1:0] rows_left;
   logic [ARR_INPUTS-2:0] vpipe;
   logic                  row_valid;
   logic [ROW_W-1:0]      aligned;

   // Lane i arrives i cycles late, so it is delayed ARR_INPUTS-1-i cycles to line up with the last lane.
   for (genvar i = 0; i < ARR_INPUTS; i++) begin : g_lane
      localparam int DEPTH = ARR_INPUTS - 1 - i;
      logic [DATA_WIDTH-1:0] lane;

      if (DEPTH == 0) begin : g_pass
         assign lane = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_dly
         logic [DATA_WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
            end else begin
               stage[0] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
               for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
            end
         end

         assign lane = stage[DEPTH-1];
      end

`ifdef ACT_ROW_WRITER_RELU_EN
      assign aligned[i*DATA_WIDTH +: DATA_WIDTH] = lane[DATA_WIDTH-1] ? '0 : lane;
`else
      assign aligned[i*DATA_WIDTH +: DATA_WIDTH] = lane;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vpipe <= '0;
      end else begin
         vpipe[0] <= in_valid;
         for (int k = 1; k < ARR_INPUTS-1; k++) vpipe[k] <= vpipe[k-1];
      end
   end

   assign row_valid = vpipe[ARR_INPUTS-2];

   // Batch control; done and the final write beat are issued on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         addr_cnt    <= '0;
         rows_left   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_wr_en   <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
      end else begin
         mem_wr_en <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  addr_cnt  <= base_addr;
                  rows_left <= num_rows;
                  if (num_rows == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (row_valid && rows_left != '0) begin
                  mem_wr_en   <= 1'b1;
                  mem_wr_addr <= addr_cnt;
                  mem_wr_data <= aligned;
                  addr_cnt    <= addr_cnt + 1'b1;
                  rows_left   <= rows_left - 1'b1;
                  if (rows_left == ADDR_WIDTH'(1)) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_act_row_writer.sv
// Directed bench for act_row_writer: per-cycle plan of start/row/reset stimulus, captured outputs compared to hand-computed tables.
// Honours ACT_ROW_WRITER_RELU_EN for the expected data of negative lanes.
module tb_act_row_writer;

   localparam int DW = 8;
   localparam int N  = 4;
   localparam int AW = 8;
   localparam int T  = 40;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] num_rows;
   logic          in_valid;
   logic [31:0]   in_data;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [31:0]   mem_wr_data;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   act_row_writer #(.DATA_WIDTH(DW), .ARR_INPUTS(N), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
      .in_valid(in_valid), .in_data(in_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data), .busy(busy), .done(done)
   );

   int nVec = 0;
   int nMis = 0;

   // Per-cycle stimulus plan; rows are given aligned and skewed onto the lanes by the driver.
   logic        vld [T];
   logic [31:0] rd [T];
   logic        st [T];
   logic [7:0]  stBase [T];
   logic [7:0]  stNum [T];
   logic        rstLow [T];

   logic        cEn [T];
   logic [7:0]  cAddr [T];
   logic [31:0] cData [T];
   logic        cDone [T];
   logic        cBusy [T];

   typedef struct {
      string           name;
      logic [7:0]      base;
      logic [7:0]      num;
      int              nFeed;
      logic [3:0][31:0] rows;
      int              nWr;
      logic [3:0][7:0]  addr;
      logic [3:0][31:0] data;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clearPlan();
      for (int t = 0; t < T; t++) begin
         vld[t] = 1'b0; rd[t] = '0; st[t] = 1'b0;
         stBase[t] = '0; stNum[t] = '0; rstLow[t] = 1'b0;
      end
   endtask

   task automatic applyStimulus();
      for (int t = 0; t < T; t++) begin
         logic [31:0] r;
         @(posedge clk);
         #1;
         rst_n     = !rstLow[t];
         start     = st[t];
         base_addr = stBase[t];
         num_rows  = stNum[t];
         in_valid  = vld[t];
         for (int i = 0; i < N; i++) begin
            if (t >= i) r = rd[t-i];
            else r = '0;
            in_data[i*DW +: DW] = r[i*DW +: DW];
         end
         #1;
         cEn[t] = mem_wr_en; cAddr[t] = mem_wr_addr; cData[t] = mem_wr_data;
         cDone[t] = done; cBusy[t] = busy;
      end
      rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
   endtask

   function automatic int countWrites();
      int n = 0;
      for (int t = 0; t < T; t++) if (cEn[t]) n++;
      return n;
   endfunction

   function automatic int countDone();
      int n = 0;
      for (int t = 0; t < T; t++) if (cDone[t]) n++;
      return n;
   endfunction

   function automatic vec_t mkVec(string name, logic [7:0] base, logic [7:0] num, int nFeed,
                                  logic [31:0] r0, logic [31:0] r1, logic [31:0] r2, logic [31:0] r3,
                                  int nWr, logic [7:0] a0, logic [7:0] a1, logic [7:0] a2,
                                  logic [31:0] d0, logic [31:0] d1, logic [31:0] d2);
      vec_t v;
      v.name = name; v.base = base; v.num = num; v.nFeed = nFeed;
      v.rows = {r3, r2, r1, r0};
      v.nWr  = nWr;
      v.addr = {8'h00, a2, a1, a0};
      v.data = {32'h0, d2, d1, d0};
      return v;
   endfunction

   vec_t vecs [6];
   logic [31:0] signExp;

   initial begin
`ifdef ACT_ROW_WRITER_RELU_EN
      signExp = 32'h7F007F00;
`else
      signExp = 32'h7F807F80;
`endif
      vecs[0] = mkVec("single", 8'h10, 8'd1, 1, 32'h04030201, 0, 0, 0,
                      1, 8'h10, 0, 0, 32'h04030201, 0, 0);
      vecs[1] = mkVec("b2b", 8'h20, 8'd3, 3, 32'h11111111, 32'h22222222, 32'h33333333, 0,
                      3, 8'h20, 8'h21, 8'h22, 32'h11111111, 32'h22222222, 32'h33333333);
      vecs[2] = mkVec("overrun", 8'h30, 8'd2, 4, 32'h0A0B0C0D, 32'h1A1B1C1D, 32'h2A2B2C2D, 32'h3A3B3C3D,
                      2, 8'h30, 8'h31, 0, 32'h0A0B0C0D, 32'h1A1B1C1D, 0);
      vecs[3] = mkVec("zero", 8'h40, 8'd0, 1, 32'h55555555, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0);
      vecs[4] = mkVec("wrap", 8'hFE, 8'd3, 3, 32'h01020304, 32'h05060708, 32'h090A0B0C, 0,
                      3, 8'hFE, 8'hFF, 8'h00, 32'h01020304, 32'h05060708, 32'h090A0B0C);
      vecs[5] = mkVec("sign", 8'h50, 8'd1, 1, 32'h7F807F80, 0, 0, 0,
                      1, 8'h50, 0, 0, signExp, 0, 0);

      rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; in_valid = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset wr_en", {31'b0, mem_wr_en}, 32'd0);
      checkOutput("reset addr", {24'b0, mem_wr_addr}, 32'd0);
      checkOutput("reset data", mem_wr_data, 32'd0);
      checkOutput("reset busy", {31'b0, busy}, 32'd0);
      checkOutput("reset done", {31'b0, done}, 32'd0);
      rst_n = 1'b1;

      // Start at cycle 1, rows from cycle 3: writes land at cycle 7 onward.
      for (int v = 0; v < 6; v++) begin
         int dt;
         clearPlan();
         st[1] = 1'b1; stBase[1] = vecs[v].base; stNum[1] = vecs[v].num;
         for (int k = 0; k < vecs[v].nFeed; k++) begin
            vld[3+k] = 1'b1;
            rd[3+k]  = vecs[v].rows[k];
         end
         applyStimulus();
         checkOutput($sformatf("%s writes", vecs[v].name), countWrites(), vecs[v].nWr);
         for (int k = 0; k < vecs[v].nWr; k++) begin
            checkOutput($sformatf("%s en%0d", vecs[v].name, k), {31'b0, cEn[7+k]}, 32'd1);
            checkOutput($sformatf("%s addr%0d", vecs[v].name, k), {24'b0, cAddr[7+k]}, {24'b0, vecs[v].addr[k]});
            checkOutput($sformatf("%s data%0d", vecs[v].name, k), cData[7+k], vecs[v].data[k]);
         end
         dt = (vecs[v].num == 0) ? 2 : 6 + vecs[v].nWr;
         checkOutput($sformatf("%s done at %0d", vecs[v].name, dt), {31'b0, cDone[dt]}, 32'd1);
         checkOutput($sformatf("%s done count", vecs[v].name), countDone(), 1);
         checkOutput($sformatf("%s busy at done", vecs[v].name), {31'b0, cBusy[dt]}, 32'd0);
         checkOutput($sformatf("%s busy end", vecs[v].name), {31'b0, cBusy[T-1]}, 32'd0);
         if (vecs[v].num != 0)
            checkOutput($sformatf("%s busy after start", vecs[v].name), {31'b0, cBusy[2]}, 32'd1);
      end

      // Start ignored while running, with gaps between rows.
      clearPlan();
      st[1] = 1'b1; stBase[1] = 8'h60; stNum[1] = 8'd3;
      st[4] = 1'b1; stBase[4] = 8'h90; stNum[4] = 8'd5;
      vld[3] = 1'b1;  rd[3]  = 32'h01010101;
      vld[6] = 1'b1;  rd[6]  = 32'h02020202;
      vld[10] = 1'b1; rd[10] = 32'h03030303;
      applyStimulus();
      checkOutput("gap writes", countWrites(), 3);
      checkOutput("gap addr0", {24'b0, cAddr[7]}, 32'h60);
      checkOutput("gap en1", {31'b0, cEn[10]}, 32'd1);
      checkOutput("gap addr1", {24'b0, cAddr[10]}, 32'h61);
      checkOutput("gap data1", cData[10], 32'h02020202);
      checkOutput("gap hold data", cData[12], 32'h02020202);
      checkOutput("gap en2", {31'b0, cEn[14]}, 32'd1);
      checkOutput("gap addr2", {24'b0, cAddr[14]}, 32'h62);
      checkOutput("gap data2", cData[14], 32'h03030303);
      checkOutput("gap done", {31'b0, cDone[14]}, 32'd1);
      checkOutput("gap done count", countDone(), 1);

      // Rows arriving without a start are dropped.
      clearPlan();
      vld[3] = 1'b1; rd[3] = 32'h12345678;
      applyStimulus();
      checkOutput("idle writes", countWrites(), 0);
      checkOutput("idle done count", countDone(), 0);

      // Reset after the first of four writes, then a fresh batch.
      clearPlan();
      st[1] = 1'b1; stBase[1] = 8'h70; stNum[1] = 8'd4;
      for (int k = 0; k < 4; k++) begin
         vld[3+k] = 1'b1;
         rd[3+k]  = 32'h44444441 + k;
      end
      rstLow[8] = 1'b1;
      st[12] = 1'b1; stBase[12] = 8'h80; stNum[12] = 8'd1;
      vld[14] = 1'b1; rd[14] = 32'h0C0D0E0F;
      applyStimulus();
      checkOutput("rst first en", {31'b0, cEn[7]}, 32'd1);
      checkOutput("rst first addr", {24'b0, cAddr[7]}, 32'h70);
      checkOutput("rst en", {31'b0, cEn[8]}, 32'd0);
      checkOutput("rst addr", {24'b0, cAddr[8]}, 32'd0);
      checkOutput("rst data", cData[8], 32'd0);
      checkOutput("rst busy", {31'b0, cBusy[8]}, 32'd0);
      checkOutput("rst writes", countWrites(), 2);
      checkOutput("rst new addr", {24'b0, cAddr[18]}, 32'h80);
      checkOutput("rst new data", cData[18], 32'h0C0D0E0F);
      checkOutput("rst new done", {31'b0, cDone[18]}, 32'd1);
      checkOutput("rst done count", countDone(), 1);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule

// File: doc/act_row_writer.md
Name: act_row_writer

Overview:
Write-side partner of the activation stage. It takes the activation lanes leaving the systolic array, one lane per column, where lane i lags lane 0 by i cycles. It realigns each row across lanes and writes it as one full-width word into the unified buffer at consecutive addresses. A start/busy/done handshake with the controller frames each row batch.

Parameters:
DATA_WIDTH, 8, bits per lane element (signed two's complement)
ARR_INPUTS, 4, number of lanes (array columns)
ADDR_WIDTH, 8, buffer address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches base_addr and num_rows
base_addr  in  ADDR_WIDTH  first write address
num_rows  in  ADDR_WIDTH  number of rows to write
in_valid  in  1  lane-0 element of a row is valid this cycle
in_data  in  DATA_WIDTH*ARR_INPUTS  skewed lane data; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
mem_wr_en  out  1  buffer write strobe
mem_wr_addr  out  ADDR_WIDTH  write address
mem_wr_data  out  DATA_WIDTH*ARR_INPUTS  aligned row; lane i in the same bit slice as the input
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FSM in IDLE, all counters and deskew registers cleared.
- Deskew:
  - Lane i passes through ARR_INPUTS-1-i register stages.
  - in_valid passes through ARR_INPUTS-1 stages to form row_valid.
  - The deskew pipeline runs in every state.
- Output register: mem_wr_en, mem_wr_addr and mem_wr_data are registered.
  - If in_valid is high at cycle c, that row appears on the outputs at cycle c+ARR_INPUTS.
  - Lane i's element for that row is sampled at cycle c+i.
- FSM states IDLE, RUN, DONE:
  - IDLE: start latches base_addr into addr_cnt and num_rows into rows_left, then moves to RUN. If num_rows==0, it moves straight to DONE and issues no writes.
  - RUN: busy=1. When row_valid is high and rows_left>0:
    - mem_wr_en=1 next cycle, with mem_wr_addr=addr_cnt.
    - addr_cnt increments and rows_left decrements.
    - When the final write is issued, the next state is DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, coincident with the final mem_wr_en beat. Then returns to IDLE.
- row_valid in IDLE or DONE, and rows beyond num_rows, are dropped: no write.
- start in RUN or DONE is ignored.
- addr_cnt wraps modulo 2^ADDR_WIDTH (0xFF+1 -> 0x00). No error flag.
- mem_wr_en is 0 on any cycle without a write; mem_wr_data holds its last value.
- Gaps in in_valid are allowed. Each row is written only when its own aligned row_valid arrives.
- rst_n asserted mid-batch aborts the batch immediately: outputs 0, no done pulse, deskew contents discarded.

Optional Feature:
ACT_ROW_WRITER_RELU_EN
- Defined: each aligned lane passes through ReLU before the output register (negative -> 0, else unchanged). The upstream activation stage may then be bypassed. Latency is unchanged.
- Undefined: data is written unmodified.

Test Plan:
- Single row. start with base_addr=0x10, num_rows=1. in_valid at cycle 5, lanes 0..3 = 0x01,0x02,0x03,0x04, each presented at cycles 5..8 respectively. Required: mem_wr_en only at cycle 9, addr 0x10, data 0x04030201; done at cycle 9; busy low afterwards.
- Back-to-back. num_rows=3, base 0x20, in_valid on 3 consecutive cycles with rows 0x11111111, 0x22222222, 0x33333333 skewed. Required: 3 consecutive writes to 0x20, 0x21, 0x22 with matching data; done with the third write.
- Overrun and ignored start. num_rows=2, feed 4 rows. Required: only 2 writes. A start pulsed during RUN does not change addresses; rows 3–4 are dropped.
- Edge cases:
  - num_rows=0: done one cycle after busy and no mem_wr_en.
  - base_addr=0xFE with num_rows=3: writes to 0xFE, 0xFF, 0x00.
- Reset mid-batch. Drop rst_n after 1 of 4 writes. Required: outputs 0 immediately, no done pulse. A new start after release works normally from its own base_addr.
- Lane data 0x80 (-128) and 0x7F:
  - With ACT_ROW_WRITER_RELU_EN defined: written as 0x00 and 0x7F.
  - Without it: written as 0x80 and 0x7F.
